// File: rtl/tape_pkg.sv
// Shared constants, state encoding and pulse-count classification for the ZX8x tape saver.
package tape_pkg;

    localparam int unsigned MIN_HIGH   = 64;
    localparam int unsigned GAP_TICKS  = 3250;
    localparam int unsigned IDLE_TICKS = 1625000;

    localparam int unsigned ZERO_MIN = 3;
    localparam int unsigned ZERO_MAX = 5;
    localparam int unsigned ONE_MIN  = 7;
    localparam int unsigned ONE_MAX  = 10;

    localparam int unsigned BUF_DEPTH = 16384;
    localparam int unsigned ADDR_W    = 14;
    // One wider than the address so a completely full buffer can be reported.
    localparam int unsigned SIZE_W    = 15;
    localparam int unsigned PCNT_W    = 4;
    localparam int unsigned TMR_W     = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } tape_state_e;

    typedef struct packed {
        logic valid;
        logic value;
    } bit_class_t;

    // Map a burst pulse count onto a data bit; counts outside both windows are invalid.
    function automatic bit_class_t bit_class(input logic [PCNT_W-1:0] cnt);
        bit_class_t res;
        res = '{valid: 1'b0, value: 1'b0};
        if (cnt >= PCNT_W'(ZERO_MIN) && cnt <= PCNT_W'(ZERO_MAX)) begin
            res = '{valid: 1'b1, value: 1'b0};
        end else if (cnt >= PCNT_W'(ONE_MIN) && cnt <= PCNT_W'(ONE_MAX)) begin
            res = '{valid: 1'b1, value: 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/tape_pulse_filter.sv
// Synchronises the mic level, detects edges and qualifies high pulses against a minimum width.
module tape_pulse_filter
    import tape_pkg::*;
#(
    parameter int unsigned HIGH_MIN = MIN_HIGH
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_ce,
    input  logic i_mic,
    output logic o_rise,
    output logic o_pulse,
    output logic o_low
);

    localparam int unsigned HCNT_W = $clog2(HIGH_MIN + 1);

    logic [1:0]        r_sync;
    logic              r_prev;
    logic [HCNT_W-1:0] r_high_cnt;
    logic              r_rise;
    logic              r_pulse;
    logic              r_low;
    logic              w_rise;
    logic              w_fall;
    logic              w_long;

    assign w_rise = r_sync[1] & ~r_prev;
    assign w_fall = ~r_sync[1] & r_prev;
    assign w_long = (r_high_cnt >= HCNT_W'(HIGH_MIN));

    // High-width counter saturates once the pulse is long enough to count.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= 2'b00;
            r_prev     <= 1'b0;
            r_high_cnt <= '0;
            r_rise     <= 1'b0;
            r_pulse    <= 1'b0;
            r_low      <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], i_mic};
            r_prev  <= r_sync[1];
            r_rise  <= w_rise;
            r_pulse <= w_fall & w_long;
            r_low   <= ~r_sync[1];
            if (w_rise) begin
                r_high_cnt <= '0;
            end else if (i_ce && r_sync[1] && !w_long) begin
                r_high_cnt <= r_high_cnt + HCNT_W'(1);
            end
        end
    end

    assign o_rise  = r_rise;
    assign o_pulse = r_pulse;
    assign o_low   = r_low;

endmodule

// File: rtl/tape_saver.sv
// ZX8x tape-out capture: pulse bursts -> bits -> bytes written into a save buffer.
// Build option TAPE_SAVER_PFILE_EN drops the leading filename bytes to leave a .p image.
module tape_saver
    import tape_pkg::*;
#(
    parameter int unsigned HIGH_MIN = MIN_HIGH,
    parameter int unsigned GAP_LEN  = GAP_TICKS,
    parameter int unsigned IDLE_LEN = IDLE_TICKS,
    parameter int unsigned DEPTH    = BUF_DEPTH
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              mic,
    input  logic              enable,
    output logic              buf_wr,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic [SIZE_W-1:0] save_size,
    output logic              save_done,
    output logic              busy,
    output logic              overflow,
    output logic              bit_err
);

    tape_state_e       r_state;
    tape_state_e       w_next;
    logic [PCNT_W-1:0] r_pulse_cnt;
    logic [TMR_W-1:0]  r_tmr;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic [SIZE_W-1:0] r_wr_ptr;
    logic              r_buf_wr;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [7:0]        r_buf_data;
    logic [SIZE_W-1:0] r_save_size;
    logic              r_save_done;
    logic              r_busy;
    logic              r_overflow;
    logic              r_bit_err;

    logic       w_rise;
    logic       w_pulse;
    logic       w_low;
    logic       w_gap_exp;
    logic       w_idle_exp;
    logic       w_resolve;
    logic       w_save_start;
    logic       w_save_end;
    logic       w_count;
    logic       w_clear;
    logic       w_byte_done;
    logic       w_full;
    logic       w_keep;
    logic       w_write;
    logic       w_drop;
    logic [7:0] w_byte;
    bit_class_t w_class;

    tape_pulse_filter #(.HIGH_MIN(HIGH_MIN)) u_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_ce    (ce),
        .i_mic   (mic),
        .o_rise  (w_rise),
        .o_pulse (w_pulse),
        .o_low   (w_low)
    );

    assign w_gap_exp  = ce && (r_tmr == TMR_W'(GAP_LEN - 1));
    assign w_idle_exp = ce && (r_tmr == TMR_W'(IDLE_LEN - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An edge always takes priority over a timer expiring in the same tick.
    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rise) w_next = ST_HIGH;
                ST_HIGH: if (w_low) w_next = ST_LOW;
                ST_LOW: begin
                    if (w_rise)         w_next = ST_HIGH;
                    else if (w_gap_exp) w_next = ST_GAP;
                end
                ST_GAP: begin
                    if (w_rise)          w_next = ST_HIGH;
                    else if (w_idle_exp) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_resolve    = 1'b0;
        w_save_start = 1'b0;
        w_save_end   = 1'b0;
        w_count      = 1'b0;
        if (enable) begin
            case (r_state)
                ST_IDLE: w_save_start = w_rise && (r_wr_ptr == '0);
                ST_HIGH: w_count      = w_pulse;
                ST_LOW:  w_resolve    = !w_rise && w_gap_exp;
                ST_GAP:  w_save_end   = !w_rise && w_idle_exp;
                default: ;
            endcase
        end
    end

    assign w_class     = bit_class(r_pulse_cnt);
    assign w_byte      = {r_shift[6:0], w_class.value};
    assign w_byte_done = w_resolve && w_class.valid && (r_bit_cnt == 3'd7);
    assign w_full      = (r_wr_ptr == SIZE_W'(DEPTH));
    assign w_clear     = (!enable && (r_state != ST_IDLE)) || w_save_end;
    assign w_write     = w_byte_done && w_keep && !w_full;
    assign w_drop      = w_byte_done && w_keep && w_full;

`ifdef TAPE_SAVER_PFILE_EN
    logic r_name_done;

    // Bytes up to and including the one with bit7 set are the filename.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_name_done <= 1'b0;
        end else if (w_clear) begin
            r_name_done <= 1'b0;
        end else if (w_byte_done && w_byte[7]) begin
            r_name_done <= 1'b1;
        end
    end

    assign w_keep = r_name_done;
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_cnt <= '0;
            r_tmr       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_buf_wr    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_save_size <= '0;
            r_save_done <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_bit_err   <= 1'b0;
        end else begin
            r_buf_wr    <= w_write;
            r_save_done <= w_save_end && (r_wr_ptr != '0);
            r_busy      <= (w_next != ST_IDLE);

            if (w_next != r_state) begin
                r_tmr <= '0;
            end else if (ce && (r_state == ST_LOW || r_state == ST_GAP)) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_clear || w_resolve) begin
                r_pulse_cnt <= '0;
            end else if (w_count && (r_pulse_cnt != '1)) begin
                r_pulse_cnt <= r_pulse_cnt + PCNT_W'(1);
            end

            if (w_clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_resolve && w_class.valid) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_clear) begin
                r_wr_ptr <= '0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + SIZE_W'(1);
            end

            if (w_write) begin
                r_buf_addr <= r_wr_ptr[ADDR_W-1:0];
                r_buf_data <= w_byte;
            end

            if (w_save_end && (r_wr_ptr != '0)) begin
                r_save_size <= r_wr_ptr;
            end

            if (w_save_start) begin
                r_bit_err  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_resolve && !w_class.valid) r_bit_err  <= 1'b1;
                if (w_drop)                      r_overflow <= 1'b1;
            end
        end
    end

    assign buf_wr    = r_buf_wr;
    assign buf_addr  = r_buf_addr;
    assign buf_data  = r_buf_data;
    assign save_size = r_save_size;
    assign save_done = r_save_done;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
    assign bit_err   = r_bit_err;

endmodule

// File: tb/tb_tape_saver.sv
// Directed bench for tape_saver with shortened timing constants and a 4-byte buffer.
module tb_tape_saver;

    localparam int unsigned T_MIN  = 6;
    localparam int unsigned T_GAP  = 40;
    localparam int unsigned T_IDLE = 200;
    localparam int unsigned T_HI   = 10;
    localparam int unsigned T_LO   = 10;
    localparam int unsigned T_GL   = 2;

    logic        clk_sys;
    logic        reset_n;
    logic        ce;
    logic        mic;
    logic        enable;
    logic        buf_wr;
    logic [13:0] buf_addr;
    logic [7:0]  buf_data;
    logic [14:0] save_size;
    logic        save_done;
    logic        busy;
    logic        overflow;
    logic        bit_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [13:0] addr_q[$];
    logic [7:0]  data_q[$];

    tape_saver #(
        .HIGH_MIN (T_MIN),
        .GAP_LEN  (T_GAP),
        .IDLE_LEN (T_IDLE),
        .DEPTH    (4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce        (ce),
        .mic       (mic),
        .enable    (enable),
        .buf_wr    (buf_wr),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .save_size (save_size),
        .save_done (save_done),
        .busy      (busy),
        .overflow  (overflow),
        .bit_err   (bit_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // ce is high on every other clock, so one tick is two clock periods.
    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clk_sys);
            ce = ~ce;
        end
    end

    // Log every write strobe and done pulse, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (buf_wr) begin
            addr_q.push_back(buf_addr);
            data_q.push_back(buf_data);
        end
        if (save_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int unsigned n);
        repeat (2 * n) @(negedge clk_sys);
    endtask

    task automatic pulse(input int unsigned hi);
        mic = 1'b1;
        wait_ticks(hi);
        mic = 1'b0;
        wait_ticks(T_LO);
    endtask

    // One burst of n qualified pulses (optionally with a short glitch) followed by the bit gap.
    task automatic send_bit(input int unsigned n, input bit glitch);
        for (int i = 0; i < int'(n); i++) begin
            pulse(T_HI);
            if (glitch && i == 1) pulse(T_GL);
        end
        wait_ticks(T_GAP + 4);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned p0, input int unsigned p1,
                             input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(b[i] ? p1 : p0, 1'b0);
    endtask

    task automatic clear_log();
        addr_q.delete();
        data_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        mic     = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_buf_wr", 32'(buf_wr), 0);
        check("rst_buf_addr", 32'(buf_addr), 0);
        check("rst_buf_data", 32'(buf_data), 0);
        check("rst_save_size", 32'(save_size), 0);
        check("rst_flags", {28'd0, save_done, busy, overflow, bit_err}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("rel_busy", 32'(busy), 0);
        enable = 1'b1;

        // Basic byte plus pulse-count window boundaries, then silence ends the save.
        clear_log();
        send_byte(8'hA5, 4, 8, 8);
        check("a5_wr_cnt", 32'(addr_q.size()), 1);
        check("a5_data", 32'(data_q[$]), 32'h A5);
        check("a5_addr", 32'(addr_q[$]), 0);
        check("a5_busy", 32'(busy), 1);
        send_byte(8'h5A, 3, 10, 8);
        check("5a_data", 32'(data_q[$]), 32'h5A);
        send_byte(8'hC3, 5, 7, 8);
        check("c3_data", 32'(data_q[$]), 32'hC3);
        check("c3_addr", 32'(addr_q[$]), 2);
        check("save1_no_early_done", 32'(done_cnt), 0);
        wait_ticks(T_IDLE + 20);
        check("save1_done", 32'(done_cnt), 1);
        check("save1_size", 32'(save_size), 3);
        check("save1_busy", 32'(busy), 0);
        check("save1_wr_cnt", 32'(addr_q.size()), 3);

        // Six-pulse burst is an error and shifts nothing; a short glitch is not counted.
        clear_log();
        send_bit(6, 1'b0);
        check("err_flag", 32'(bit_err), 1);
        send_byte(8'h3C, 4, 8, 8);
        check("err_wr_cnt", 32'(addr_q.size()), 1);
        check("err_data", 32'(data_q[$]), 32'h3C);
        check("err_addr", 32'(addr_q[$]), 0);
        send_bit(5, 1'b1);
        send_byte(8'h17, 4, 8, 7);
        check("glitch_data", 32'(data_q[$]), 32'h17);
        check("glitch_addr", 32'(addr_q[$]), 1);
        check("err_sticky", 32'(bit_err), 1);
        wait_ticks(T_IDLE + 20);
        check("save2_done", 32'(done_cnt), 2);
        check("save2_size", 32'(save_size), 2);

        // Buffer fills after four bytes; the fifth is dropped and flags overflow.
        clear_log();
        send_byte(8'h11, 4, 8, 8);
        check("ovf_err_cleared", 32'(bit_err), 0);
        send_byte(8'h22, 4, 8, 8);
        send_byte(8'h33, 4, 8, 8);
        send_byte(8'h44, 4, 8, 8);
        check("full_no_ovf", 32'(overflow), 0);
        send_byte(8'h55, 4, 8, 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_wr_cnt", 32'(addr_q.size()), 4);
        check("ovf_last_addr", 32'(addr_q[$]), 3);
        check("ovf_last_data", 32'(data_q[$]), 32'h44);
        wait_ticks(T_IDLE + 20);
        check("save3_done", 32'(done_cnt), 3);
        check("save3_size", 32'(save_size), 4);
        check("ovf_sticky", 32'(overflow), 1);

        // Dropping enable abandons the save without a done pulse.
        clear_log();
        send_byte(8'h81, 4, 8, 8);
        check("en_ovf_cleared", 32'(overflow), 0);
        send_byte(8'h7E, 4, 8, 8);
        check("en_wr_cnt", 32'(addr_q.size()), 2);
        enable = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("en_busy", 32'(busy), 0);
        wait_ticks(T_GAP + T_IDLE + 20);
        check("en_no_done", 32'(done_cnt), 3);
        check("en_size_kept", 32'(save_size), 4);
        enable = 1'b1;

        // Filename bytes 0x26,0xB9 precede the program bytes 0x00,0x11.
        clear_log();
        send_byte(8'h26, 4, 8, 8);
        send_byte(8'hB9, 4, 8, 8);
        send_byte(8'h00, 4, 8, 8);
        send_byte(8'h11, 4, 8, 8);
        wait_ticks(T_IDLE + 20);
        check("pf_done", 32'(done_cnt), 4);
`ifdef TAPE_SAVER_PFILE_EN
        check("pf_wr_cnt", 32'(addr_q.size()), 2);
        check("pf_first_data", 32'(data_q[0]), 32'h00);
        check("pf_first_addr", 32'(addr_q[0]), 0);
        check("pf_last_data", 32'(data_q[$]), 32'h11);
        check("pf_last_addr", 32'(addr_q[$]), 1);
        check("pf_size", 32'(save_size), 2);
`else
        check("pf_wr_cnt", 32'(addr_q.size()), 4);
        check("pf_first_data", 32'(data_q[0]), 32'h26);
        check("pf_first_addr", 32'(addr_q[0]), 0);
        check("pf_last_data", 32'(data_q[$]), 32'h11);
        check("pf_last_addr", 32'(addr_q[$]), 3);
        check("pf_size", 32'(save_size), 4);
`endif

        // Asynchronous reset in the middle of a burst clears everything at once.
        clear_log();
        send_byte(8'h42, 4, 8, 8);
        check("rb_data", 32'(buf_data), 32'h42);
        pulse(T_HI);
        mic = 1'b1;
        wait_ticks(3);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_addr_data", {10'd0, buf_addr, buf_data}, 0);
        check("mid_rst_size", 32'(save_size), 0);
        check("mid_rst_flags", {27'd0, buf_wr, save_done, busy, overflow, bit_err}, 0);
        mic = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (6) @(negedge clk_sys);
        check("post_rst_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
